// File: rtl/cve2_md_sequencer.sv
// Iterative RV32M multiply/divide sequencer: ABS -> 32 x ITER -> FINISH around one shared adder.
// Returns one 32-bit result with a single-cycle valid pulse; kill_i aborts at any stage.
module cve2_md_sequencer #(
  parameter bit DivZeroFastPath = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [1:0]  op_i,
  input  logic        signed_a_i,
  input  logic        signed_b_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  localparam logic [1:0] MdOpMull = 2'd0;
  localparam logic [1:0] MdOpMulh = 2'd1;
  localparam logic [1:0] MdOpDiv  = 2'd2;
  localparam logic [1:0] MdOpRem  = 2'd3;

  typedef enum logic [1:0] {StIdle, StAbs, StIter, StFinish} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic [5:0]  cnt_q, cnt_d;

  // Shared 33-bit adder.
  logic [32:0] add_a, add_b, add_sum;
  logic        add_cin;

  logic        is_div, a_neg, b_neg, b_zero, neg_res;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh;
  logic [31:0] neg_hi, fin_res;

  assign add_sum = add_a + add_b + {32'b0, add_cin};

  assign is_div = (op_q == MdOpDiv) || (op_q == MdOpRem);
  assign a_neg  = sign_a_q & lo_q[31];
  assign b_neg  = sign_b_q & b_q[31];
  assign b_zero = (b_q == 32'd0);
  assign rem_sh = {hi_q, lo_q[31]};

  always_comb begin
    unique case (op_q)
      MdOpRem: neg_res = a_neg;
      MdOpDiv: neg_res = (a_neg ^ b_neg) & ~b_zero;
      default: neg_res = a_neg ^ b_neg;
    endcase
  end

  // Adder operand selection per state.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      StAbs: begin
        add_a   = {1'b0, ~lo_q};
        add_cin = 1'b1;
      end
      StIter: begin
        if (is_div) begin
          add_a   = rem_sh;
          add_b   = ~{1'b0, b_q};
          add_cin = 1'b1;
        end else begin
          add_a = {1'b0, hi_q};
          add_b = lo_q[0] ? {1'b0, b_q} : 33'd0;
        end
      end
      StFinish: begin
        add_a   = {1'b0, ~((op_q == MdOpRem) ? hi_q : lo_q)};
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign a_abs = a_neg ? add_sum[31:0] : lo_q;
  assign b_abs = b_neg ? (~b_q + 32'd1) : b_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_i && !kill_i) begin
          op_d     = op_i;
          sign_a_d = signed_a_i;
          sign_b_d = signed_b_i;
          hi_d     = '0;
          lo_d     = op_a_i;
          b_d      = op_b_i;
          state_d  = StAbs;
        end
      end
      StAbs: begin
        neg_d = neg_res;
        hi_d  = '0;
        lo_d  = a_abs;
        b_d   = b_abs;
        cnt_d = 6'd31;
        state_d = StIter;
        // Preload the values the full schedule would converge to for a zero divisor.
        if (DivZeroFastPath && is_div && b_zero) begin
          hi_d    = a_abs;
          lo_d    = '1;
          state_d = StFinish;
        end
      end
      StIter: begin
        if (is_div) begin
          if (!add_sum[32]) begin
            hi_d = add_sum[31:0];
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = rem_sh[31:0];
            lo_d = {lo_q[30:0], 1'b0};
          end
        end else begin
          hi_d = add_sum[32:1];
          lo_d = {add_sum[0], lo_q[31:1]};
        end
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd0) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (kill_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // Upper half of the 64-bit product negation takes the carry out of the low half.
  assign neg_hi = ~hi_q + {31'b0, add_sum[32]};

  always_comb begin
    unique case (op_q)
      MdOpMull: fin_res = neg_q ? add_sum[31:0] : lo_q;
      MdOpMulh: fin_res = neg_q ? neg_hi : hi_q;
      MdOpDiv:  fin_res = neg_q ? add_sum[31:0] : lo_q;
      MdOpRem:  fin_res = neg_q ? add_sum[31:0] : hi_q;
      default:  fin_res = '0;
    endcase
  end

  assign busy_o   = (state_q != StIdle);
  assign valid_o  = (state_q == StFinish) && !kill_i;
  assign result_o = valid_o ? fin_res : 32'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cve2_md_sequencer.sv
// Scoreboard bench: two DUTs (fast and slow divide-by-zero) share stimulus; expected results
// come from an integer-arithmetic model and are checked by per-DUT monitors.
module tb_cve2_md_sequencer;

  localparam logic [1:0] OpMull = 2'd0;
  localparam logic [1:0] OpMulh = 2'd1;
  localparam logic [1:0] OpDiv  = 2'd2;
  localparam logic [1:0] OpRem  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0, kill = 1'b0, sa = 1'b0, sb = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy_f, valid_f, busy_s, valid_s;
  logic [31:0] res_f, res_s;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] cyc;
  } exp_t;

  exp_t q_f[$];
  exp_t q_s[$];

  cve2_md_sequencer #(.DivZeroFastPath(1'b1)) u_fast (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .op_i(op), .signed_a_i(sa), .signed_b_i(sb),
    .op_a_i(a), .op_b_i(b), .kill_i(kill), .busy_o(busy_f), .valid_o(valid_f), .result_o(res_f)
  );

  cve2_md_sequencer #(.DivZeroFastPath(1'b0)) u_slow (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .op_i(op), .signed_a_i(sa), .signed_b_i(sb),
    .op_a_i(a), .op_b_i(b), .kill_i(kill), .busy_o(busy_s), .valid_o(valid_s), .result_o(res_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_md(input logic [1:0] o, input logic s_a, input logic s_b,
                                         input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ea, eb, p;
    longint      va, vb, qq, rr;
    ea = s_a ? {{32{x[31]}}, x} : {32'b0, x};
    eb = s_b ? {{32{y[31]}}, y} : {32'b0, y};
    p  = ea * eb;
    va = $signed(ea);
    vb = $signed(eb);
    if (o == OpMull) return p[31:0];
    if (o == OpMulh) return p[63:32];
    if (y == 32'd0) return (o == OpDiv) ? 32'hFFFF_FFFF : x;
    qq = va / vb;
    rr = va % vb;
    return (o == OpDiv) ? qq[31:0] : rr[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (valid_f) begin
      if (q_f.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fast_unexpected_valid: got valid with result %h, required none", res_f);
      end else begin
        e = q_f.pop_front();
        check("fast_result", res_f, e.res);
        check("fast_cycle", cyc, e.cyc);
      end
    end else if (res_f !== 32'd0) begin
      check("fast_result_when_invalid", res_f, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (valid_s) begin
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL slow_unexpected_valid: got valid with result %h, required none", res_s);
      end else begin
        e = q_s.pop_front();
        check("slow_result", res_s, e.res);
        check("slow_cycle", cyc, e.cyc);
      end
    end else if (res_s !== 32'd0) begin
      check("slow_result_when_invalid", res_s, 32'd0);
    end
  end

  // Called at a negedge; the request is accepted at the following posedge (relative cycle 0).
  task automatic issue(input logic [1:0] o, input logic s_a, input logic s_b,
                       input logic [31:0] x, input logic [31:0] y, input bit expect_res);
    exp_t e;
    op = o; sa = s_a; sb = s_b; a = x; b = y; req = 1'b1;
    if (expect_res) begin
      e.res = ref_md(o, s_a, s_b, x, y);
      e.cyc = cyc + 34;
      q_s.push_back(e);
      if ((o == OpDiv || o == OpRem) && y == 32'd0) e.cyc = cyc + 2;
      q_f.push_back(e);
    end
    @(negedge clk);
    req = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_f || busy_s) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_f || busy_s) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic s_a, input logic s_b,
                     input logic [31:0] x, input logic [31:0] y);
    issue(o, s_a, s_b, x, y, 1'b1);
    wait_idle();
  endtask

  function automatic logic [31:0] pick(input int unsigned sel);
    logic [31:0] v;
    unique case (sel)
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1;
      4: v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset_busy_f", {31'b0, busy_f}, 32'd0);
    check("reset_valid_f", {31'b0, valid_f}, 32'd0);
    check("reset_result_f", res_f, 32'd0);
    check("reset_busy_s", {31'b0, busy_s}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // MULL with busy window
    issue(OpMull, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0009, 1'b1);
    check("mull_busy_cycle1", {31'b0, busy_f}, 32'd1);
    repeat (33) @(negedge clk);
    check("mull_busy_cycle34", {31'b0, busy_f}, 32'd1);
    check("mull_known_value", ref_md(OpMull, 1'b0, 1'b0, 32'h1234_5678, 32'd9), 32'hA3D7_0A38);
    @(negedge clk);
    check("mull_busy_cycle35", {31'b0, busy_f}, 32'd0);

    run(OpMulh, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(OpMulh, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(OpMulh, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
    run(OpDiv,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    run(OpRem,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    run(OpDiv,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(OpRem,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(OpDiv,  1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000);
    run(OpRem,  1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000);
    run(OpDiv,  1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000);
    run(OpRem,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000);

    // Kill in relative cycle 10, then a new MULL in cycle 11
    issue(OpDiv, 1'b1, 1'b1, 32'h7654_3210, 32'h0000_0033, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_f", {31'b0, busy_f}, 32'd0);
    check("kill_busy_s", {31'b0, busy_s}, 32'd0);
    run(OpMull, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0001_0003);

    // Kill in the FINISH cycle
    issue(OpMull, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0);
    repeat (33) @(negedge clk);
    kill = 1'b1;
    #1;
    check("kill_finish_valid_f", {31'b0, valid_f}, 32'd0);
    check("kill_finish_valid_s", {31'b0, valid_s}, 32'd0);
    check("kill_finish_result_f", res_f, 32'd0);
    @(negedge clk);
    kill = 1'b0;
    check("kill_finish_busy_f", {31'b0, busy_f}, 32'd0);

    // Kill together with a request in IDLE
    op = OpMull; a = 32'd3; b = 32'd4; req = 1'b1; kill = 1'b1;
    @(negedge clk);
    req = 1'b0; kill = 1'b0;
    check("kill_req_idle_busy", {31'b0, busy_f}, 32'd0);

    // Back-to-back: second request held through FINISH and the following IDLE cycle
    begin
      exp_t e;
      issue(OpMull, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0000_1001, 1'b1);
      repeat (33) @(negedge clk);
      op = OpMull; sa = 1'b1; sb = 1'b1; a = 32'hFFFF_FF00; b = 32'h0000_0777; req = 1'b1;
      e.res = ref_md(OpMull, 1'b1, 1'b1, 32'hFFFF_FF00, 32'h0000_0777);
      e.cyc = cyc + 35;
      q_f.push_back(e);
      q_s.push_back(e);
      repeat (2) @(negedge clk);
      req = 1'b0;
      wait_idle();
    end

    // Asynchronous reset mid-operation
    issue(OpDiv, 1'b0, 1'b0, 32'hCAFE_0000, 32'h0000_0011, 1'b0);
    repeat (19) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_busy_f", {31'b0, busy_f}, 32'd0);
    check("rst_mid_busy_s", {31'b0, busy_s}, 32'd0);
    check("rst_mid_valid_f", {31'b0, valid_f}, 32'd0);
    check("rst_mid_result_f", res_f, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          pick($urandom_range(0, 7)), pick($urandom_range(0, 7)));
    end

    repeat (5) @(negedge clk);
    check("fast_queue_drained", q_f.size(), 32'd0);
    check("slow_queue_drained", q_s.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cve2_md_sequencer.md
# cve2_md_sequencer

Iterative RV32M multiply/divide sequencer for the RV32MSlow configuration. It accepts one operation from the ID/EX stage, selected by `md_op_e` (MULL, MULH, DIV, REM) plus per-operand signedness. It runs a shared 33-bit adder through a fixed 32-step shift-add or restoring-divide schedule and returns a single 32-bit result with a one-cycle valid pulse. It sits beside the ALU in the EX block. The ID stage stalls on `busy_o` and the controller's kill aborts it.

## Interface
Parameters:
- `DivZeroFastPath`, default 1'b1: when 1, a divide or remainder by zero skips the iterations and finishes in the cycle after ABS; when 0, it runs the full schedule and still returns the specified result.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  start request; sampled only in IDLE; a one-cycle pulse is sufficient.
- `op_i`  in  2  `md_op_e`: MD_OP_MULL / MD_OP_MULH / MD_OP_DIV / MD_OP_REM.
- `signed_a_i`, `signed_b_i`  in  1 each  treat `op_a_i` / `op_b_i` as two's complement.
- `op_a_i`, `op_b_i`  in  32  operands; captured on acceptance, need not be held.
- `kill_i`  in  1  abort the in-flight operation (exception/flush).
- `busy_o`  out  1  state != IDLE.
- `valid_o`  out  1  result valid, one-cycle pulse.
- `result_o`  out  32  result; 0 whenever `valid_o` = 0.

## Operation
- **States:** IDLE, ABS, ITER, FINISH.
- **IDLE:** on `req_i` & ~`kill_i`:
  - capture op, signs, operands;
  - go to ABS.
- **ABS:** replace each operand by its magnitude when that operand is signed and negative, using the shared adder.
  - Magnitude is 32-bit unsigned, so 0x80000000 maps to 2^31.
  - Compute `neg_res`:
    - MUL*: sa^sb.
    - DIV: sa^sb, forced 0 when b==0.
    - REM: sa.
  - Here sa = signed_a_i & a[31] and sb = signed_b_i & b[31].
  - Load the 6-bit counter with 31.
  - Go to ITER. If the op is DIV/REM, b==0 and `DivZeroFastPath`, go to FINISH instead.
- **ITER, multiply:** 64-bit accumulator {hi,lo}, with lo preloaded with |a|.
  - Each step: if lo[0], add |b| to hi (33-bit sum), then shift {carry,hi,lo} right by 1.
- **ITER, divide:** restoring division.
  - Each step: rem = {rem[31:0], quo[31]}; quo <<= 1; trial = rem − |b| (33-bit).
  - If non-negative: rem = trial and quo[0] = 1.
- **ITER exit:** counter decrements each cycle; go to FINISH after the step with counter==0.
- **FINISH:** apply two's-complement negation when `neg_res`, then select the result:
  - MULL: low 32 bits of the 64-bit product.
  - MULH: high 32 bits of the 64-bit product.
  - DIV: quotient.
  - REM: remainder.
  - The negation reuses the adder; 64-bit negation for MUL.
  - Go to IDLE.
- **Divide by zero:**
  - DIV/DIVU gives 0xFFFFFFFF.
  - REM/REMU gives the original `op_a_i`.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, produced naturally by the magnitude scheme.
- **`kill_i`:** in ABS, ITER or FINISH, go to IDLE at the next edge.
  - `valid_o` is gated to 0 in a killed FINISH cycle.
  - `kill_i` with `req_i` in IDLE: the request is not accepted.
- **Busy behaviour:** `req_i` is ignored while busy.

## Timing
- **Reset values:** state IDLE, all datapath registers 0, `busy_o`=0, `valid_o`=0, `result_o`=0.
- **Normal operation:** with `req_i` accepted in cycle 0:
  - ABS in cycle 1.
  - ITER in cycles 2–33.
  - FINISH in cycle 34, with `valid_o`=1 and `result_o` valid combinationally.
  - Latency is 34 cycles for every op.
- **Fast divide-by-zero:** FINISH in cycle 2.
- **`busy_o`:** high in cycles 1 through FINISH inclusive; low in the cycle after FINISH.
- **Back-to-back:** a new `req_i` is accepted in the cycle immediately after FINISH (IDLE). No request is accepted during FINISH.
- **Reset mid-operation:** asynchronous return to IDLE with all registers cleared. No `valid_o` follows.
- **Combinational paths:** none from `req_i` to outputs. `kill_i` reaches `valid_o` and `result_o` combinationally only.

## Test plan
- MULL unsigned 0x12345678 × 0x00000009 -> `valid_o` in cycle 34, `result_o`=0xA3D70A38; `busy_o` high in cycles 1–34.
- MULH with both operands unsigned, 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH signed×signed with the same operands (−1 × −1) -> 0x00000000; MULHSU 0xFFFFFFFF(signed) × 0x00000002 -> 0xFFFFFFFF.
- Signed DIV −7/2 -> 0xFFFFFFFD; signed REM −7%2 -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF signed -> 0x80000000, REM -> 0.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF with `valid_o` in cycle 2; REM 0x1234 % 0 -> 0x1234; repeat with `DivZeroFastPath`=0 -> same values in cycle 34.
- `kill_i` asserted in cycle 10 of a DIV -> `busy_o` low from cycle 11, no `valid_o`. `kill_i` in the FINISH cycle -> `valid_o`=0. A new MULL requested in cycle 11 completes in cycle 45 with a correct result.
- Back-to-back: MULL accepted in cycle 0, second `req_i` held through cycles 34–35 -> second op accepted in cycle 35, `valid_o` in cycle 69. `rst_ni` pulsed low in cycle 20 -> outputs 0 immediately, no pulse afterwards.
